// File: rtl/spislave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spislave_pkg                                                  |
// | Purpose  : Shared constants and types for the spislave SPI responder.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package spislave_pkg;

  // Frame-level sequencer states.
  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_LOAD  = 2'd1,
    STATE_SHIFT = 2'd2
  } state_e;

  // Plain-vector encodings of the same states, for tools that dislike enums.
  localparam logic [1:0] S_IDLE  = STATE_IDLE;
  localparam logic [1:0] S_LOAD  = STATE_LOAD;
  localparam logic [1:0] S_SHIFT = STATE_SHIFT;

  localparam int               CNT_W             = 4;
  localparam logic [CNT_W-1:0] BITS_PER_FRAME    = 4'd8;
  localparam logic [7:0]       IDLE_BYTE_DEFAULT = 8'hFF;

  // Byte presented at the start of a frame: buffered data if any, else filler.
  function automatic logic [7:0] pick_tx_byte(
    input logic       empty,
    input logic [7:0] buffered,
    input logic [7:0] filler
  );
    return empty ? filler : buffered;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spislave_spisync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spisync                                                       |
// | Purpose  : STAGES-deep flop chain bringing an asynchronous pin into clk. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spisync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spislave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spislave                                                      |
// | Purpose  : SPI mode-0 responder, 8-bit MSB-first, oversampled on clk.    |
// |            Define SPISLAVE_OVERRUN_EN to add rxack / rxoverrun.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spislave
  import spislave_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txdata,
  input  logic       txwrite,
  output logic       txempty,
  output logic [7:0] rxdata,
  output logic       rxvalid,
  output logic       selected,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
`ifdef SPISLAVE_OVERRUN_EN
  ,
  input  logic       rxack,
  output logic       rxoverrun
`endif
);

  // ---------------------------------------------------------------- pin sync
  logic sck_s;
  logic cs_n_s;
  logic mosi_s;

  spisync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk (clk),
    .rst (rst),
    .d   (spi_sck),
    .q   (sck_s)
  );

  spisync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .d   (spi_cs_n),
    .q   (cs_n_s)
  );

  spisync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d   (spi_mosi),
    .q   (mosi_s)
  );

  // --------------------------------------------------------- edge detection
  logic       r_sck_d;
  logic       r_cs_n_d;
  logic [1:0] r_prime;
  logic       w_primed;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_cs_fall;

  // The synchroniser resets to 1, so its first real sample of a low cs_n would
  // look like a falling edge. cs_n history is only tracked once the chain
  // holds genuine pin samples; until then it reads as "already low".
  assign w_primed = (r_prime == 2'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_d  <= 1'b1;
      r_cs_n_d <= 1'b0;
      r_prime  <= 2'd0;
    end else begin
      r_sck_d <= sck_s;
      if (!w_primed) begin
        r_prime <= r_prime + 2'd1;
      end else begin
        r_cs_n_d <= cs_n_s;
      end
    end
  end

  assign w_sck_rise = sck_s & ~r_sck_d;
  assign w_sck_fall = ~sck_s & r_sck_d;
  assign w_cs_fall  = w_primed & r_cs_n_d & ~cs_n_s;

  // ------------------------------------------------------------- sequencer
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    if (cs_n_s) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_state_nxt = S_LOAD;
        S_LOAD:  w_state_nxt = S_SHIFT;
        S_SHIFT: w_state_nxt = S_SHIFT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ------------------------------------------------------------- datapath
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_rx_shift;
  logic [7:0]       r_tx_shift;
  logic [7:0]       r_txbuf;
  logic             r_txempty;
  logic             r_reload;
  logic             r_miso;
  logic [7:0]       r_rxdata;
  logic             r_rxvalid;
  logic             w_in_shift;
  logic             w_frame_done;
  logic             w_load;
  logic [7:0]       w_load_byte;

  assign w_in_shift   = (r_state == S_SHIFT) & ~cs_n_s;
  assign w_frame_done = w_in_shift & (r_cnt == BITS_PER_FRAME);
  // A load happens on frame start and on the first sck fall after each byte.
  assign w_load       = ~cs_n_s & ((r_state == S_LOAD) |
                                   ((r_state == S_SHIFT) & w_sck_fall & r_reload));
  assign w_load_byte  = pick_tx_byte(r_txempty, r_txbuf, IDLE_BYTE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rx_shift <= 8'h00;
      r_reload   <= 1'b0;
      r_rxdata   <= 8'h00;
      r_rxvalid  <= 1'b0;
    end else begin
      r_rxvalid <= w_frame_done;
      if (w_frame_done) begin
        r_rxdata <= r_rx_shift;
      end

      if (cs_n_s || (r_state == S_LOAD)) begin
        r_cnt <= '0;
      end else if (w_in_shift && w_sck_rise) begin
        r_cnt <= r_cnt + 4'd1;
      end else if (w_frame_done) begin
        r_cnt <= '0;
      end

      if (w_in_shift && w_sck_rise) begin
        r_rx_shift <= {r_rx_shift[6:0], mosi_s};
      end

      if (cs_n_s || (r_state == S_LOAD)) begin
        r_reload <= 1'b0;
      end else if (w_frame_done) begin
        r_reload <= 1'b1;
      end else if (w_load) begin
        r_reload <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_shift <= 8'h00;
      r_miso     <= 1'b1;
    end else if (w_load) begin
      r_tx_shift <= w_load_byte;
      r_miso     <= w_load_byte[7];
    end else if (w_in_shift && w_sck_fall) begin
      r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      r_miso     <= r_tx_shift[6];
    end
  end

  // A write coinciding with a load lands after the load has taken the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txbuf   <= 8'h00;
      r_txempty <= 1'b1;
    end else if (txwrite) begin
      r_txbuf   <= txdata;
      r_txempty <= 1'b0;
    end else if (w_load && !r_txempty) begin
      r_txempty <= 1'b1;
    end
  end

  // ----------------------------------------------------------- overrun flag
`ifdef SPISLAVE_OVERRUN_EN
  logic r_pending;
  logic r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_rxvalid) begin
        r_pending <= 1'b1;
      end else if (rxack) begin
        r_pending <= 1'b0;
      end

      if (r_rxvalid && r_pending && !rxack) begin
        r_overrun <= 1'b1;
      end else if (rxack) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rxoverrun = r_overrun;
`endif

  // ---------------------------------------------------------------- outputs
  assign txempty     = r_txempty;
  assign rxdata      = r_rxdata;
  assign rxvalid     = r_rxvalid;
  assign selected    = (r_state != S_IDLE);
  assign spi_miso    = r_miso;
  assign spi_miso_oe = selected;

endmodule
`default_nettype wire
